// File: rtl/riscv_defs.sv
// Shared encodings for the data-memory controller: access sizes, FSM states,
// and the alignment rule that sends an access to the error path.
package riscv_defs;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_dmem_lane.sv
// Byte/half lane handling: extracts and extends load data from a RAM word, and
// builds the read-modify-write word for sub-word stores.
module riscv_dmem_lane
  import riscv_defs::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rword_i[7:0];
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      default: byte_sel = rword_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    case (size_i)
      SZ_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_o = rword_i;
    endcase

    merged_o = rword_i;
    case (size_i)
      SZ_BYTE: begin
        case (addr_lo_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = rword_i;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Single-port data-memory controller: one request at a time, sub-word stores
// done as read-modify-write, misaligned/illegal accesses answered with an error.
module riscv_dmem_ctrl
  import riscv_defs::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_e            state_q, state_d;
  logic              live_q;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, merge_q, rdata_q;
  logic [31:0]       lane_load, lane_merge;
  logic              accept, load_resp;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign accept         = req_valid & req_ready;
  assign load_resp      = (state_q == ST_WAIT) & ~we_q;

  riscv_dmem_lane u_lane (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .addr_lo_i  (addr_q[1:0]),
    .rword_i    (ram_dout),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merged_o   (lane_merge)
  );

  // live_q keeps req_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (load_resp)               rdata_q <= lane_load;
      else if (state_q == ST_ERR)  rdata_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr[ADDR_W+1:0];
      wdata_q <= req_wdata;
    end
    if (state_q == ST_WAIT) merge_q <= lane_merge;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = rdata_q;
    case (state_q)
      ST_IDLE: begin
        req_ready = live_q;
        if (accept) begin
          if (access_bad(req_size, req_addr[1:0]))  state_d = ST_ERR;
          else if (req_we && req_size == SZ_WORD)   state_d = ST_WR;
          else                                      state_d = ST_RD;
        end
      end
      ST_RD: begin
        ram_en   = 1'b1;
        ram_addr = addr_q[ADDR_W+1:2];
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (we_q) begin
          state_d = ST_WR;
        end else begin
          resp_valid = 1'b1;
          resp_rdata = lane_load;
          state_d    = ST_IDLE;
        end
      end
      ST_WR: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = addr_q[ADDR_W+1:2];
        ram_din    = (size_q == SZ_WORD) ? wdata_q : merge_q;
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        resp_rdata = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
